// File: rtl/clk_div_meter_pkg.sv
// Shared definitions for the clock-divider measurement block: defaults and
// the measurement FSM state type.
package clk_div_meter_pkg;

    // Default counter width; the longest measurable period is 2**WIDTH-1 cycles.
    localparam int unsigned DEF_WIDTH       = 16;

    // Default synchronizer depth on the asynchronous input (must be >= 2).
    localparam int unsigned DEF_SYNC_STAGES = 2;

    // Measurement FSM: IDLE waits for an arming edge, MEASURE counts.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } meter_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous level plus a rising-edge
// detector on the synchronized output. Reusable for buttons and resets.
module sync_edge_det
    import clk_div_meter_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              s_d;

    // Shift the input through the synchronizer chain and delay the last stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            s_d    <= sync_q[STAGES-1];
        end
    end

    assign s    = sync_q[STAGES-1];
    assign rise = s & ~s_d;

endmodule

// File: rtl/clk_div_meter.sv
// Period / high-time meter for a slow divided clock or pulse train.
// Each rise-to-rise interval of the synchronized input is counted in clk
// cycles; results are published with a one-cycle valid strobe. Two equal
// consecutive periods raise locked; a missing edge for 2**WIDTH-1 cycles
// raises the sticky timeout flag.
module clk_div_meter
    import clk_div_meter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    meter_state_t     state;
    logic [WIDTH-1:0] per_cnt;
    logic [WIDTH-1:0] hi_cnt;
    logic             s;
    logic             rise;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .s     (s),
        .rise  (rise)
    );

    // Measurement FSM with counters, result registers, lock and timeout.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                // Disable overrides any edge; results and timeout are kept.
                state   <= ST_IDLE;
                per_cnt <= '0;
                hi_cnt  <= '0;
                locked  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                        if (rise) begin
                            // First edge only arms; the rise cycle itself is high.
                            state   <= ST_MEASURE;
                            per_cnt <= CNT_ONE;
                            hi_cnt  <= CNT_ONE;
                        end
                    end
                    ST_MEASURE: begin
                        if (rise) begin
                            // Edge wins over saturation, so period may equal CNT_MAX.
                            period    <= per_cnt;
                            high_time <= hi_cnt;
                            valid     <= 1'b1;
                            timeout   <= 1'b0;
                            locked    <= (per_cnt == period) && (period != '0);
                            per_cnt   <= CNT_ONE;
                            hi_cnt    <= CNT_ONE;
                        end else if (per_cnt == CNT_MAX) begin
                            state   <= ST_IDLE;
                            per_cnt <= '0;
                            hi_cnt  <= '0;
                            timeout <= 1'b1;
                            locked  <= 1'b0;
                        end else begin
                            per_cnt <= per_cnt + CNT_ONE;
                            if (s) begin
                                hi_cnt <= hi_cnt + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        per_cnt <= '0;
                        hi_cnt  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
